pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the team's single-bit full adder.
- Adds or subtracts two WIDTH-bit operands.
- Operands are split into STAGES equal chunks; each chunk is added one pipeline stage later, with the carry registered between stages.
- Valid/ready handshake on both sides. Used as the datapath adder wherever a full-width single-cycle ripple carry misses timing.

Parameters:
- WIDTH, 32, operand and result width in bits; must be divisible by STAGES.
- STAGES, 4, number of pipeline stages; each adds CHUNK = WIDTH/STAGES bits; 1 <= STAGES <= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in; used only when sub=0.
- sub  input  1  0: A+B+c_in; 1: A-B (A + ~B + 1; c_in ignored).
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- c_out  output  1  carry out of the MSB; when sub=1, 1 = no borrow (A >= B unsigned).
- ovf  output  1  two's-complement signed overflow of the operation.

Behaviour:
- Reset is asynchronous and active-high. While rst=1, all stage valid bits, partial-sum registers and carry registers clear to 0, so out_valid=0, sum=0, c_out=0 and ovf=0. in_ready=1 once rst deasserts.
- Global advance: adv = out_ready | ~out_valid. in_ready = adv (combinational).
- All stages shift together when adv=1 and hold when adv=0. Bubbles are not collapsed.
- Input transfer: in_valid & in_ready. Stage-0 valid loads in_valid when adv=1, so a bubble enters when in_valid=0.
- Operand preparation: B' = sub ? ~b : b; cin' = sub ? 1 : c_in.
- Stage k (0..STAGES-1):
  - adds chunk k of A and B' (bits k*CHUNK+CHUNK-1 : k*CHUNK) plus the carry from stage k-1 (cin' for stage 0);
  - registers the CHUNK-bit partial sum and the carry-out;
  - delays not-yet-used operand chunks and already-computed sum chunks alongside, so each beat's data moves as a unit.
- ovf: taken in the last stage as the carry into the MSB XOR the carry out of the MSB.
- Latency: exactly STAGES cycles from the input transfer to out_valid=1 when out_ready is held high. Throughput: 1 beat/cycle.
- Output hold: while out_valid=1 and out_ready=0, sum, c_out and ovf stay stable and the pipeline freezes. No beat is lost or duplicated.
- Simultaneous events:
  - If out_valid=1 and out_ready=1 in the same cycle as in_valid=1, both transfers occur.
  - in_valid=1 with in_ready=0 accepts nothing; the source must hold its data.
- Wrap-around: sum wraps modulo 2^WIDTH and c_out reports the wrap. There is no saturation.
- Reset mid-operation: all in-flight beats are discarded immediately (asynchronous). No partial result appears after reset.
- STAGES=1: degenerates to a registered full-width adder with latency 1.

Test Plan:
1. WIDTH=8, STAGES=2, out_ready=1; a=0x0F, b=0x01, c_in=0, sub=0 -> exactly 2 cycles later sum=0x10, c_out=0, ovf=0 (carry crosses the chunk boundary).
2. WIDTH=8, STAGES=2; a=0x7F, b=0x01, sub=0 -> sum=0x80, ovf=1, c_out=0. Then a=0xFF, b=0x01, c_in=1 -> sum=0x01, c_out=1, ovf=0.
3. WIDTH=8, STAGES=2, subtract; a=0x05, b=0x07, sub=1, c_in=1 -> sum=0xFE, c_out=0 (borrow), ovf=0. Then a=0x80, b=0x01, sub=1 -> sum=0x7F, ovf=1, c_out=1.
4. Default params; stream 100 random beats with random in_valid gaps and random out_ready stalls -> results in order, each equal to the reference model modulo 2^32; outputs stable during every stall; no drops or duplicates.
5. Fill the pipeline (4 beats), hold out_ready=0 for 5 cycles -> in_ready=0 throughout, sum unchanged; release -> beats drain one per cycle in order.
6. Assert rst for 1 cycle with 3 beats in flight -> out_valid=0 and sum=0 immediately. After release, a new beat a=1, b=2 -> sum=3 after 4 cycles, with no stale results emitted.

Source files
------------

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: operands are split into STAGES chunks, one chunk is
// summed per stage and the carry is registered between stages.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int CHUNK = WIDTH / STAGES;

    logic             adv_s;
    logic [WIDTH-1:0] b_prep_s;
    logic             cin_prep_s;

    assign adv_s    = out_ready | ~out_valid;
    assign in_ready = adv_s;

    // Subtraction is A + ~B + 1, so the invert and forced carry happen up front.
    always_comb begin
        if (sub) begin
            b_prep_s   = ~b;
            cin_prep_s = 1'b1;
        end else begin
            b_prep_s   = b;
            cin_prep_s = c_in;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             valid_src_s;
        logic             cin_src_s;
        logic [WIDTH-1:0] a_src_s;
        logic [WIDTH-1:0] b_src_s;
        logic [WIDTH-1:0] sum_src_s;
        logic [WIDTH-1:0] sum_nxt_s;
        logic [CHUNK:0]   add_s;
        logic             valid_r;
        logic             carry_r;
        logic [WIDTH-1:0] sum_r;

        if (k == 0) begin : g_head
            assign valid_src_s = in_valid;
            assign a_src_s     = a;
            assign b_src_s     = b_prep_s;
            assign sum_src_s   = {WIDTH{1'b0}};
            assign cin_src_s   = cin_prep_s;
        end else begin : g_body
            assign valid_src_s = g_stage[k-1].valid_r;
            assign a_src_s     = g_stage[k-1].g_fwd.a_r;
            assign b_src_s     = g_stage[k-1].g_fwd.b_r;
            assign sum_src_s   = g_stage[k-1].sum_r;
            assign cin_src_s   = g_stage[k-1].carry_r;
        end

        assign add_s = {1'b0, a_src_s[k*CHUNK +: CHUNK]}
                     + {1'b0, b_src_s[k*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, cin_src_s};

        // Merge this stage's chunk into the partial sum travelling with the beat.
        always_comb begin
            sum_nxt_s = sum_src_s;
            sum_nxt_s[k*CHUNK +: CHUNK] = add_s[CHUNK-1:0];
        end

        // Stage register: valid, partial sum and chunk carry shift together on adv.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_r <= 1'b0;
                carry_r <= 1'b0;
                sum_r   <= {WIDTH{1'b0}};
            end else if (adv_s) begin
                valid_r <= valid_src_s;
                carry_r <= add_s[CHUNK];
                sum_r   <= sum_nxt_s;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [WIDTH-1:0] a_r;
            logic [WIDTH-1:0] b_r;

            // Operands ride along so later stages still see their chunks.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_r <= {WIDTH{1'b0}};
                    b_r <= {WIDTH{1'b0}};
                end else if (adv_s) begin
                    a_r <= a_src_s;
                    b_r <= b_src_s;
                end
            end
        end else begin : g_tail
            logic ovf_r;
            logic msb_cin_s;
            logic unused_s;

            // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
            assign msb_cin_s = a_src_s[WIDTH-1] ^ b_src_s[WIDTH-1] ^ sum_nxt_s[WIDTH-1];
            assign unused_s  = ^{a_src_s, b_src_s};

            // Signed overflow registered alongside the final chunk.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_r <= 1'b0;
                end else if (adv_s) begin
                    ovf_r <= msb_cin_s ^ add_s[CHUNK];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_r;
    assign sum       = g_stage[STAGES-1].sum_r;
    assign c_out     = g_stage[STAGES-1].carry_r;
    assign ovf       = g_stage[STAGES-1].g_tail.ovf_r;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: 32-bit/4-stage random stream plus
// directed 8-bit/2-stage corner vectors.
module tb_pipelined_adder;

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        v;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        c_in;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        c_out;
    logic        ovf;

    logic        iv8, ir8, ov8, cin8, sub8, co8, ovf8;
    logic [7:0]  a8, b8, sum8;

    int   checks = 0;
    int   fails  = 0;
    bit   rand_ready = 1'b0;
    exp_t q[$];

    pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .c_out(c_out), .ovf(ovf)
    );

    pipelined_adder #(.WIDTH(8), .STAGES(2)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .c_in(cin8), .sub(sub8), .out_valid(ov8),
        .out_ready(1'b1), .sum(sum8), .c_out(co8), .ovf(ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the unsigned and signed views.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic ci, input logic sb);
        exp_t   e;
        longint ux, uy, r, sx, sy, sr;
        ux = {32'd0, x};
        uy = {32'd0, y};
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (sb) begin
            r   = ux - uy;
            e.c = (ux >= uy);
            sr  = sx - sy;
        end else begin
            r   = ux + uy + longint'(ci);
            e.c = (r > 64'sd4294967295);
            sr  = sx + sy + longint'(ci);
        end
        e.s = r[31:0];
        e.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard push on every accepted input beat.
    always @(posedge clk) begin
        if (!rst && in_valid && in_ready) q.push_back(model(a, b, c_in, sub));
    end

    // Monitor: compare presented output with the oldest outstanding beat.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_out: got sum %0h with no beat outstanding", sum);
            end else begin
                chk("sum", {32'd0, sum}, {32'd0, q[0].s});
                chk("c_out", {63'd0, c_out}, {63'd0, q[0].c});
                chk("ovf", {63'd0, ovf}, {63'd0, q[0].v});
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    // Random downstream stalls while enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic ci, input logic sb);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        a = av; b = bv; c_in = ci; sub = sb; in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            else n++;
            @(posedge clk);
            #1;
            if (n > 200) begin
                checks++;
                fails++;
                $display("FAIL send_timeout: in_ready stuck 0, required 1");
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    // Issue one beat then expect out_valid exactly STAGES cycles after transfer.
    task automatic latency4(input string nm, input logic [31:0] av, input logic [31:0] bv);
        send(av, bv, 1'b0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk({nm, "_valid"}, {63'd0, out_valid}, (c == 4) ? 64'd1 : 64'd0);
        end
    endtask

    task automatic dir8(input string nm, input logic [7:0] x, input logic [7:0] y,
                        input logic ci, input logic sb, input logic [7:0] es,
                        input logic ec, input logic ev);
        @(negedge clk);
        a8 = x; b8 = y; cin8 = ci; sub8 = sb; iv8 = 1'b1;
        chk({nm, "_in_ready"}, {63'd0, ir8}, 64'd1);
        @(posedge clk);
        #1 iv8 = 1'b0;
        @(negedge clk);
        chk({nm, "_early"}, {63'd0, ov8}, 64'd0);
        @(negedge clk);
        chk({nm, "_valid"}, {63'd0, ov8}, 64'd1);
        chk({nm, "_sum"}, {56'd0, sum8}, {56'd0, es});
        chk({nm, "_c_out"}, {63'd0, co8}, {63'd0, ec});
        chk({nm, "_ovf"}, {63'd0, ovf8}, {63'd0, ev});
    endtask

    task automatic drain();
        int n;
        n = 0;
        rand_ready = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        while (q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("drain_empty", 64'(q.size()), 64'd0);
        #1;
    endtask

    initial begin
        logic [31:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = 32'd0; b = 32'd0; c_in = 1'b0; sub = 1'b0;
        iv8 = 1'b0; a8 = 8'd0; b8 = 8'd0; cin8 = 1'b0; sub8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_sum", {32'd0, sum}, 64'd0);
        chk("rst_c_out", {63'd0, c_out}, 64'd0);
        chk("rst_ovf", {63'd0, ovf}, 64'd0);
        @(negedge clk) rst = 1'b0;
        #1 chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        dir8("d8_carry_chunk", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
        dir8("d8_pos_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        dir8("d8_wrap", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
        dir8("d8_borrow", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
        dir8("d8_sub_ovf", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

        @(posedge clk);
        #1 out_ready = 1'b1;
        latency4("lat32", 32'hFFFF_FFFF, 32'h0000_0001);
        drain();

        // Random stream with input gaps and output stalls.
        rand_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            case ($urandom_range(0, 4))
                0:       ra = 32'hFFFF_FFFF;
                1:       ra = 32'h8000_0000;
                2:       ra = 32'h7FFF_FFFF;
                default: ra = $urandom;
            endcase
            rb = $urandom;
            send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain();

        // Fill with output blocked, hold five cycles, then drain one per cycle.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send($urandom, $urandom, 1'b0, 1'($urandom_range(0, 1)));
        repeat (5) begin
            @(negedge clk);
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drain_valid", {63'd0, out_valid}, 64'd1);
        end
        @(negedge clk);
        chk("drain_done", {63'd0, out_valid}, 64'd0);

        // Reset with three beats in flight.
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_sum", {32'd0, sum}, 64'd0);
        q.delete();
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        latency4("after_rst", 32'd1, 32'd2);
        chk("after_rst_sum", {32'd0, sum}, 64'd3);
        repeat (4) begin
            @(negedge clk);
            chk("no_stale", {63'd0, out_valid}, 64'd0);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
